led_slot_scheduler: RTL



---
 rtl/led_sched_pkg.sv | 42 ++++
 rtl/led_slot_scheduler_prescaler.sv | 36 +++
 rtl/led_slot_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// Shared types, constants and arbitration helpers for the LED slot scheduler.
// Helpers take requests zero-padded to MAX_REQ bits so one function serves every NUM_REQ.
package led_sched_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    localparam int unsigned LED_W   = 3;
    localparam int unsigned MAX_REQ = 8;

    // Padding bits are zero, so scanning modulo MAX_REQ matches scanning modulo NUM_REQ.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         last_owner);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = last_owner + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [2:0] fp_pick(input logic [MAX_REQ-1:0] req);
        logic [2:0] win;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (!found && req[k]) begin
                win   = 3'(k);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/led_slot_scheduler_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
// A synchronous clear restarts the count so callers can align tick phase to an event.
module led_tick_prescaler #(
    parameter int unsigned TICK_DIV = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_MAX);
    assign tick = wrap;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_slot_scheduler.sv
// Time-shares the 3-bit LED bank between NUM_REQ requesters in fixed tick-aligned slots.
// Optional macro LED_SCHED_PREEMPT_EN: fixed-priority arbitration with preemption by lower indices.
module led_slot_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TICK_DIV    = 200000,
    parameter int unsigned BLINK_TICKS = 5,
    parameter int unsigned SLOT_TICKS  = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [LED_W*NUM_REQ-1:0]   pattern,
    output logic [NUM_REQ-1:0]         grant,
    output logic [LED_W-1:0]           led,
    output logic                       busy,
    output logic                       tick
);

    localparam int unsigned OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SLOT_W  = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(SLOT_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

    state_e               state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [OWN_W-1:0]     last_owner_q, last_owner_d;
    logic [LED_W-1:0]     pattern_q, pattern_d;
    logic                 phase_q, phase_d;
    logic [SLOT_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 pre_clear;
    logic                 preempt;
    logic [OWN_W-1:0]     winner;

    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .tick  (tick)
    );

`ifdef LED_SCHED_PREEMPT_EN
    assign winner = OWN_W'(fp_pick(MAX_REQ'(req)));

    always_comb begin
        preempt = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (OWN_W'(j) < owner_q)) begin
                preempt = 1'b1;
            end
        end
    end
`else
    assign winner  = OWN_W'(rr_pick(MAX_REQ'(req), 3'(last_owner_q)));
    assign preempt = 1'b0;
`endif

    assign busy  = (state_q == GRANT);
    assign grant = busy ? (NUM_REQ'(1) << owner_q) : '0;
    assign led   = (busy && phase_q) ? pattern_q : '0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        pattern_d    = pattern_q;
        phase_d      = phase_q;
        slot_cnt_d   = slot_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        pre_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    owner_d     = winner;
                    pattern_d   = pattern[LED_W*int'(winner) +: LED_W];
                    phase_d     = 1'b1;
                    slot_cnt_d  = '0;
                    blink_cnt_d = '0;
                    pre_clear   = 1'b1;
                end
            end
            GRANT: begin
                if (tick) begin
                    slot_cnt_d = (slot_cnt_q == SLOT_MAX) ? '0 : slot_cnt_q + SLOT_W'(1);
                    if (blink_cnt_q == BLINK_MAX) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
                // Slot expiry, owner drop and preemption all collapse into one release.
                if ((tick && (slot_cnt_q == SLOT_MAX)) || !req[owner_q] || preempt) begin
                    state_d      = GAP;
                    last_owner_d = owner_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OWN_W'(NUM_REQ - 1);
            pattern_q    <= '0;
            phase_q      <= 1'b0;
            slot_cnt_q   <= '0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            pattern_q    <= pattern_d;
            phase_q      <= phase_d;
            slot_cnt_q   <= slot_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

endmodule
